// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues sequential PC requests to instruction memory and
// queues the in-order responses for decode. Redirects flush the queue and drop stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        decode_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic          redirect_pc_unused;

    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Queued plus in-flight words may never exceed DEPTH, so a response always has a free slot.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (drop_cnt == '0) && !redirect_valid;
    assign pop       = (count != '0) && decode_ready && !redirect_valid;

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[head] : 32'h0;
    assign pc         = inst_valid ? q_pc[head]   : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight after this edge belongs to the old path.
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            resp_pc     <= {redirect_pc[31:2], 2'b00};
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(resp_fire);
            drop_cnt    <= outstanding - CW'(resp_fire);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire) begin
                if (drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                else
                    resp_pc <= resp_pc + 32'd4;
            end
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= resp_pc;
            q_inst[tail] <= imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order variable-latency memory model feeds the DUT and a
// scoreboard of expected {pc, inst} pairs is checked as decode consumes the queue head.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 2;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        decode_ready;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .pc              (pc),
        .decode_ready    (decode_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cycle = 0;
    int unsigned epoch = 0;
    int          occ = 0;
    int          mem_lat = 1;
    logic        mem_ready = 1'b1;
    logic [31:0] exp_addr = RESET_PC;
    mem_req_t    pend[$];
    exp_t        sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any clock edge.
    task automatic resetDut();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        decode_ready    = 1'b0;
        imem_req_ready  = mem_ready;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_pc", pc, 32'h0);
        pend.delete();
        sb.delete();
        occ      = 0;
        epoch    = epoch + 1;
        exp_addr = RESET_PC;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        cycle = cycle + 1;
    endtask

    // One clock cycle: drive inputs (memory model included), check outputs, advance the models.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic dready);
        int          out_before;
        logic        resp_now;
        mem_req_t    r;
        logic        exp_rv;
        logic        req_fire;
        out_before = pend.size();
        resp_now   = 1'b0;
        r          = '{addr: 32'h0, due: 0, epoch: 0};
        if (pend.size() > 0 && pend[0].due <= cycle) begin
            resp_now = 1'b1;
            r        = pend[0];
            void'(pend.pop_front());
        end
        redirect_valid  = redir;
        redirect_pc     = rpc;
        decode_ready    = dready;
        imem_req_ready  = mem_ready;
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(r.addr) : 32'hDEAD_BEEF;
        #1;
        exp_rv = !redir && (occ + out_before < DEPTH);
        checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid)
            checkOutput("req_addr", imem_req_addr, exp_addr);
        checkOutput("inst_valid", 32'(inst_valid), 32'(occ > 0));
        if (occ == 0) begin
            checkOutput("idle_inst", inst, 32'h0);
            checkOutput("idle_pc", pc, 32'h0);
        end else if (sb.size() > 0) begin
            checkOutput("head_pc", pc, sb[0].pc);
            checkOutput("head_inst", inst, sb[0].data);
        end
        req_fire = imem_req_valid && imem_req_ready;
        if (!redir && occ > 0 && dready) begin
            occ = occ - 1;
            void'(sb.pop_front());
        end
        if (resp_now && !redir && r.epoch == epoch)
            occ = occ + 1;
        if (req_fire) begin
            pend.push_back('{addr: imem_req_addr, due: cycle + mem_lat, epoch: epoch});
            sb.push_back('{pc: exp_addr, data: mem_word(exp_addr)});
            exp_addr = exp_addr + 32'd4;
        end
        if (redir) begin
            epoch    = epoch + 1;
            sb.delete();
            occ      = 0;
            exp_addr = {rpc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cycle = cycle + 1;
    endtask

    initial begin
        rst = 1'b1;

        $display("[TB] steady streaming and memory backpressure");
        mem_lat = 1; mem_ready = 1'b1;
        resetDut();
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            mem_ready = i[0];
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        mem_ready = 1'b1;

        $display("[TB] decode stall fills the queue");
        resetDut();
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] redirect with two slow requests in flight");
        mem_lat = 3;
        resetDut();
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0102, 1'b1);
        repeat (14) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] redirect with same-cycle response and pop");
        mem_lat = 1;
        resetDut();
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_1000, 1'b1);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_2004, 1'b1);
        applyStimulus(1'b1, 32'h0000_3008, 1'b1);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] reset with full queue");
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("full_before_rst", 32'(occ), 32'(DEPTH));
        resetDut();
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
